// File: rtl/core_seq_pkg.sv
// Shared encodings for the rv32i multi-cycle sequencer: state codes,
// trap cause codes and default timing parameters.
package core_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WRBK   = 3'd4,
    S_TRAP   = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd3;

  localparam int DEF_MEM_TIMEOUT = 16;
  localparam int DEF_CNT_W       = 5;

endpackage

// File: rtl/seq_timeout_cnt.sv
// Wait-cycle counter shared by the FETCH and MEM handshakes; flags expiry
// once MEM_TIMEOUT-1 cycles have elapsed without a clear.
module seq_timeout_cnt #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the rv32i core: stage strobes, imem/dmem
// handshakes, trap detection, halt handling and retired-instruction count.
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        halt_i,
  input  logic        imem_ack_i,
  input  logic        dec_mem_op_i,
  input  logic        dec_illegal_i,
  input  logic        exec_done_i,
  input  logic        dmem_ack_i,
  output logic        imem_req_o,
  output logic        dmem_req_o,
  output logic        state_fetch_o,
  output logic        state_dec_o,
  output logic        state_exec_o,
  output logic        state_mem_o,
  output logic        state_wrbk_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o,
  output logic        halted_o,
  output logic [31:0] instret_o
);

  state_e      state_q, state_d;
  logic        mem_op_q, mem_op_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] instret_q, instret_d;
  logic        to_expired;
  logic        to_clr;
  logic        to_en;

  always_comb begin
    state_d   = state_q;
    mem_op_d  = mem_op_q;
    cause_d   = cause_q;
    instret_d = instret_q;
    unique case (state_q)
      S_FETCH: begin
        // An ack arriving in the expiry cycle still completes the fetch.
        if (imem_ack_i) begin
          state_d = S_DECODE;
        end else if (to_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_IMEM_TO;
        end
      end
      S_DECODE: begin
        mem_op_d = dec_mem_op_i;
        if (dec_illegal_i) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done_i) begin
          state_d = mem_op_q ? S_MEM : S_WRBK;
        end
      end
      S_MEM: begin
        if (dmem_ack_i) begin
          state_d = S_WRBK;
        end else if (to_expired) begin
          state_d = S_TRAP;
          cause_d = CAUSE_DMEM_TO;
        end
      end
      S_WRBK: begin
        instret_d = instret_q + 32'd1;
        state_d   = halt_i ? S_HALT : S_FETCH;
      end
      S_TRAP: begin
        state_d = halt_i ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (!halt_i) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign to_clr = (state_d != state_q);
  assign to_en  = (state_q == S_FETCH) || (state_q == S_MEM);

  seq_timeout_cnt #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (to_clr),
    .en      (to_en),
    .expired (to_expired)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= S_FETCH;
      mem_op_q  <= 1'b0;
      cause_q   <= CAUSE_NONE;
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      mem_op_q  <= mem_op_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

  // Every output decodes from registers only, so acks never reach outputs combinationally.
  assign state_fetch_o = (state_q == S_FETCH);
  assign state_dec_o   = (state_q == S_DECODE);
  assign state_exec_o  = (state_q == S_EXEC);
  assign state_mem_o   = (state_q == S_MEM);
  assign state_wrbk_o  = (state_q == S_WRBK);
  assign imem_req_o    = (state_q == S_FETCH);
  assign dmem_req_o    = (state_q == S_MEM);
  assign trap_o        = (state_q == S_TRAP);
  assign halted_o      = (state_q == S_HALT);
  assign trap_cause_o  = cause_q;
  assign instret_o     = instret_q;

endmodule
